pixel_capture_sequencer: RTL
============================

// Module: pixel_capture_sequencer
// PURPOSE
// - Per-node WS2812 chain controller: decodes synced input, captures the first CHAN_BITS bits of each frame as this node's pixel.
// - Then drives the reshaper's i_passthru_en so only the remaining bits are forwarded downstream.
// - Re-arms on every latch (long low) period.
// - Sits between the input synchroniser and the reshaper. Shares i_signal_synced with it.
// PARAMETERS
// - CHAN_BITS          24    bits captured per frame (MSB first)
// - BIT_THRESH_CYCLES  30    high time in cycles >= this decodes '1', else '0'
// - LATCH_CYCLES       2500  consecutive low cycles that constitute a latch/reset period
// PORTS
// - i_clk            in   1          clock
// - i_reset_n        in   1          asynchronous active-low reset
// - i_enable         in   1          block enable; low forces WAIT_LATCH
// - i_signal_synced  in   1          synchronised serial input (same signal fed to reshaper)
// - o_passthru_en    out  1          to reshaper i_passthru_en; 1 only in FORWARD
// - o_pixel_data     out  CHAN_BITS  last complete captured pixel
// - o_pixel_valid    out  1          1-cycle pulse when o_pixel_data updates
// - o_frame_done     out  1          1-cycle pulse on latch while in FORWARD
// - o_frame_err      out  1          1-cycle pulse on latch in CAPTURE with 0 < bits < CHAN_BITS
// BEHAVIOUR
// - Reset: all outputs 0, state WAIT_LATCH, counters 0, r_sig_d 0.
// - Edge detect uses r_sig_d, the registered i_signal_synced.
//   - rise = sig & !r_sig_d; fall = !sig & r_sig_d.
// - High counter: 8-bit, saturates at 255.
//   - Loads 1 on rise, increments while sig high.
//   - At fall it equals the high-pulse length in cycles; bit = (hcnt >= BIT_THRESH_CYCLES).
// - Low counter: width $clog2(LATCH_CYCLES+1); cleared while sig high, increments while low, saturates at LATCH_CYCLES.
// - latch_evt fires once, in the cycle the low counter reaches LATCH_CYCLES.
//   - Does not repeat until sig goes high again.
// - FSM, registered state:
//   - WAIT_LATCH: passthru 0; bits ignored; latch_evt -> CAPTURE.
//   - CAPTURE: each fall shifts the decoded bit into shreg LSB and increments bitcnt.
//     - On fall completing bit CHAN_BITS: o_pixel_data <= shreg, o_pixel_valid = 1 (next cycle), bitcnt <= 0, -> FORWARD.
//     - latch_evt with bitcnt != 0: o_frame_err pulse, bitcnt <= 0, o_pixel_data unchanged, stay CAPTURE.
//     - latch_evt with bitcnt == 0: no pulse, stay CAPTURE.
//   - FORWARD: passthru 1; falls ignored.
//     - latch_evt -> CAPTURE with o_frame_done pulse; passthru 0 the following cycle.
// - o_passthru_en is a registered decode of state == FORWARD.
//   - Rises 1 cycle after the fall that completed capture, always within the low phase, so the reshaper never sees a partial pulse.
// - Pulse outputs (o_pixel_valid, o_frame_done, o_frame_err) are registered, exactly 1 cycle, never overlap.
// - i_enable low (any state): next cycle state WAIT_LATCH, passthru 0, bitcnt 0.
//   - o_pixel_data retained; no pulses.
// - Async reset mid-frame: immediate return to reset values.
//   - Line is not trusted until a full latch is seen.
// - Pulse longer than 255 cycles: hcnt saturates, decodes '1'.
// TESTING
// - Reset, hold line low 2500 cycles -> state CAPTURE at cycle 2500, o_passthru_en 0, no pulses.
// - Frame 0xA53C0F ('0' = 20 cyc high, '1' = 40 cyc high, 1.25 us period) -> o_pixel_valid 1 cycle, o_pixel_data = 0xA53C0F.
//   - o_passthru_en = 1 from the cycle after the 24th fall.
//   - A further 48 bits leave o_pixel_data unchanged.
// - After forwarding, low 2500 cycles -> o_frame_done 1 cycle, o_passthru_en 0.
//   - Next frame 0x000001 -> o_pixel_data = 0x000001.
// - Latch after only 10 captured bits -> o_frame_err 1 cycle, o_pixel_data unchanged, next 24 bits captured correctly.
// - Threshold boundaries:
//   - High 29 cycles -> '0'; high 30 cycles -> '1'.
//   - Low 2499 cycles then high -> no latch_evt; low 2500 cycles -> latch_evt.
// - Enable and reset interruptions:
//   - Drop i_enable mid-FORWARD -> o_passthru_en 0 next cycle; re-enable mid-frame -> no capture until a 2500-cycle latch.
//   - Assert i_reset_n low mid-CAPTURE -> all outputs 0 immediately.

Source files
------------

// File: rtl/pixel_capture_sequencer_if.sv
// pixel_capture_sequencer_if: control, serial-line and capture-result signals for one chain node
`timescale 1ns/1ps
interface pixel_capture_sequencer_if #(parameter int CHAN_BITS = 24);
  logic                 i_enable;
  logic                 i_signal_synced;
  logic                 o_passthru_en;
  logic [CHAN_BITS-1:0] o_pixel_data;
  logic                 o_pixel_valid;
  logic                 o_frame_done;
  logic                 o_frame_err;
  modport master (
    output i_enable, i_signal_synced,
    input  o_passthru_en, o_pixel_data, o_pixel_valid, o_frame_done, o_frame_err
  );
  modport slave (
    input  i_enable, i_signal_synced,
    output o_passthru_en, o_pixel_data, o_pixel_valid, o_frame_done, o_frame_err
  );
endinterface

// File: rtl/pixel_capture_sequencer.sv
// pixel_capture_sequencer: captures the first CHAN_BITS WS2812 bits of each frame, then enables passthrough of the rest
`timescale 1ns/1ps
module pixel_capture_sequencer #(
  parameter int CHAN_BITS         = 24,
  parameter int BIT_THRESH_CYCLES = 30,
  parameter int LATCH_CYCLES      = 2500
) (
  input  logic                     i_clk,
  input  logic                     i_reset_n,
  pixel_capture_sequencer_if.slave bus
);
  localparam int LW = $clog2(LATCH_CYCLES + 1);
  localparam int BW = $clog2(CHAN_BITS + 1);
  typedef enum logic [1:0] {WAIT_LATCH, CAPTURE, FORWARD} state_t;
  state_t               state, state_nxt;
  logic                 r_sig_d;
  logic [7:0]           hcnt;
  logic [LW-1:0]        lcnt;
  logic [BW-1:0]        bitcnt, bitcnt_nxt;
  logic [CHAN_BITS-1:0] shreg, shreg_nxt, pix, pix_nxt;
  logic                 valid, done, err, pass;
  logic                 valid_nxt, done_nxt, err_nxt;
  logic                 sig, rise, fall, bit_val, latch_evt;
  assign sig       = bus.i_signal_synced;
  assign rise      = sig & ~r_sig_d;
  assign fall      = ~sig & r_sig_d;
  assign bit_val   = hcnt >= 8'(BIT_THRESH_CYCLES);
  assign latch_evt = ~sig & (lcnt == LW'(LATCH_CYCLES - 1));
  always_comb begin
    state_nxt  = state;
    bitcnt_nxt = bitcnt;
    shreg_nxt  = shreg;
    pix_nxt    = pix;
    valid_nxt  = 1'b0;
    done_nxt   = 1'b0;
    err_nxt    = 1'b0;
    if (!bus.i_enable) begin
      state_nxt  = WAIT_LATCH;
      bitcnt_nxt = '0;
    end else begin
      case (state)
        WAIT_LATCH: state_nxt = latch_evt ? CAPTURE : WAIT_LATCH;
        CAPTURE: begin
          if (fall) begin
            shreg_nxt  = {shreg[CHAN_BITS-2:0], bit_val};
            bitcnt_nxt = bitcnt + BW'(1);
            if (bitcnt == BW'(CHAN_BITS - 1)) begin
              pix_nxt    = shreg_nxt;
              valid_nxt  = 1'b1;
              bitcnt_nxt = '0;
              state_nxt  = FORWARD;
            end
          end else if (latch_evt) begin
            err_nxt    = bitcnt != '0;
            bitcnt_nxt = '0;
          end
        end
        FORWARD: begin
          done_nxt  = latch_evt;
          state_nxt = latch_evt ? CAPTURE : FORWARD;
        end
        default: state_nxt = WAIT_LATCH;
      endcase
    end
  end
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state   <= WAIT_LATCH;
      r_sig_d <= 1'b0;
      hcnt    <= '0;
      lcnt    <= '0;
      bitcnt  <= '0;
      shreg   <= '0;
      pix     <= '0;
      valid   <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
      pass    <= 1'b0;
    end else begin
      state   <= state_nxt;
      r_sig_d <= sig;
      hcnt    <= rise ? 8'd1 : (sig && hcnt != 8'hff) ? hcnt + 8'd1 : hcnt;
      lcnt    <= sig ? '0 : (lcnt != LW'(LATCH_CYCLES)) ? lcnt + LW'(1) : lcnt;
      bitcnt  <= bitcnt_nxt;
      shreg   <= shreg_nxt;
      pix     <= pix_nxt;
      valid   <= valid_nxt;
      done    <= done_nxt;
      err     <= err_nxt;
      pass    <= state_nxt == FORWARD;
    end
  end
  assign bus.o_passthru_en = pass;
  assign bus.o_pixel_data  = pix;
  assign bus.o_pixel_valid = valid;
  assign bus.o_frame_done  = done;
  assign bus.o_frame_err   = err;
endmodule
